// File: rtl/dmem_dma_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_dma_arbiter_pkg
// Description : Shared types and constants for the data-memory / DMA arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_dma_arbiter_pkg;

  // Data memory returns read data this many cycles after the re cycle.
  localparam int MEM_LAT = 1;

  // DMA transfer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_dma_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_dma_arbiter_if
// Description : CPU, DMA control/stream and data-memory signals of the
//               arbiter. slave = arbiter side, master = surrounding system.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_dma_arbiter_if #(
  parameter int LEN_W = 8
);
  // CPU memory stage
  logic             cpu_re;
  logic             cpu_we;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             cpu_stall;
  // DMA control
  logic             dma_start;
  logic [31:0]      dma_src;
  logic [LEN_W-1:0] dma_len;
  logic             dma_busy;
  logic             dma_done;
  // DMA output stream
  logic             dma_out_valid;
  logic [31:0]      dma_out_data;
  logic [LEN_W-1:0] dma_out_index;
  logic             dma_out_ready;
  // Data memory
  logic [31:0]      mem_addr;
  logic             mem_re;
  logic             mem_we;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
    input  dma_start, dma_src, dma_len, dma_out_ready, mem_rdata,
    output cpu_rdata, cpu_stall, dma_busy, dma_done,
    output dma_out_valid, dma_out_data, dma_out_index,
    output mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata,
    output dma_start, dma_src, dma_len, dma_out_ready, mem_rdata,
    input  cpu_rdata, cpu_stall, dma_busy, dma_done,
    input  dma_out_valid, dma_out_data, dma_out_index,
    input  mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/dmem_dma_arbiter_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dmem_dma_arbiter_out_buffer
// Description : Single-entry valid/ready holding register for DMA output
//               words and their transfer index.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_dma_arbiter_out_buffer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             load,       // returning memory word this cycle
  input  logic [31:0]      load_data,
  input  logic [LEN_W-1:0] load_idx,
  input  logic             ready,
  output logic             valid,
  output logic [31:0]      data,
  output logic [LEN_W-1:0] idx
);

  logic             r_valid;
  logic [31:0]      r_data;
  logic [LEN_W-1:0] r_idx;

  // Capture returning word; a load wins over a same-cycle drain because the
  // issue rule only lets a refill land when the old word is leaving.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
      r_idx   <= load_idx;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign idx   = r_idx;

endmodule
`default_nettype wire

// File: rtl/dmem_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_dma_arbiter
// Description : Shares the single-port data memory between the CPU memory
//               stage (priority) and a block-read DMA engine. A starvation
//               counter forces a DMA slot after MAX_WAIT lost cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_dma_arbiter
  import dmem_dma_arbiter_pkg::*;
#(
  parameter int          LEN_W     = 8,
  parameter int unsigned ADDR_STEP = 1,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst,   // asynchronous, active-low
  dmem_dma_arbiter_if.slave bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  dma_state_e       r_state;
  dma_state_e       w_state_nxt;
  logic [31:0]      r_addr;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_issue_idx;
  logic [LEN_W-1:0] r_tag;
  logic             r_inflight;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic w_cpu_req;
  logic w_accept;
  logic w_dma_want;
  logic w_dma_win;
  logic w_busy;
  logic w_done;
  logic w_hold_valid;

  assign w_cpu_req = bus.cpu_re | bus.cpu_we;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state, DMA slot request and arbitration decision.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_dma_want  = 1'b0;
    w_dma_win   = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.dma_start) begin
          w_accept    = 1'b1;
          w_state_nxt = (bus.dma_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        w_busy     = 1'b1;
        // One read in flight at a time, and only when the buffer slot will
        // be free by the time the word returns.
        w_dma_want = !r_inflight && (!w_hold_valid || bus.dma_out_ready);
        w_dma_win  = w_dma_want &&
                     (!w_cpu_req || (r_wait_cnt == WAIT_W'(MAX_WAIT)));
        if (w_dma_win && (r_remaining == LEN_W'(1))) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        if (!r_inflight && !w_hold_valid) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Memory port mux: DMA owns the port only on a won slot.
  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_re    = bus.cpu_re;
    bus.mem_we    = bus.cpu_we;
    bus.cpu_stall = 1'b0;
    if (w_dma_win) begin
      bus.mem_addr  = r_addr;
      bus.mem_re    = 1'b1;
      bus.mem_we    = 1'b0;
      bus.cpu_stall = w_cpu_req;
    end
  end

  // DMA address/count/tag bookkeeping and starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_issue_idx <= '0;
      r_tag       <= '0;
      r_inflight  <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_addr      <= bus.dma_src;
        r_remaining <= bus.dma_len;
        r_issue_idx <= '0;
      end
      if (w_dma_win) begin
        r_addr      <= r_addr + 32'(ADDR_STEP);
        r_remaining <= r_remaining - LEN_W'(1);
        r_tag       <= r_issue_idx;
        r_issue_idx <= r_issue_idx + LEN_W'(1);
      end
      // Read data returns exactly one cycle after the grant.
      r_inflight <= w_dma_win;
      if (w_dma_want && !w_dma_win) begin
        if (r_wait_cnt != WAIT_W'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  dmem_dma_arbiter_out_buffer #(
    .LEN_W (LEN_W)
  ) u_out_buffer (
    .clk       (clk),
    .rst       (rst),
    .load      (r_inflight),
    .load_data (bus.mem_rdata),
    .load_idx  (r_tag),
    .ready     (bus.dma_out_ready),
    .valid     (w_hold_valid),
    .data      (bus.dma_out_data),
    .idx       (bus.dma_out_index)
  );

  assign bus.dma_out_valid = w_hold_valid;
  assign bus.dma_busy      = w_busy;
  assign bus.dma_done      = w_done;
  assign bus.mem_wdata     = bus.cpu_wdata;
  assign bus.cpu_rdata     = bus.mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_dma_arbiter
// Description : Directed self-checking bench for dmem_dma_arbiter with a
//               256-word behavioural data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_dma_arbiter;

  logic clk;
  logic rst;

  dmem_dma_arbiter_if #(.LEN_W(8)) dbus ();

  dmem_dma_arbiter #(
    .LEN_W     (8),
    .ADDR_STEP (1),
    .MAX_WAIT  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory, one cycle read latency.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (dbus.mem_we) mem[dbus.mem_addr[7:0]] <= dbus.mem_wdata;
    if (dbus.mem_re) dbus.mem_rdata <= mem[dbus.mem_addr[7:0]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] pat(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {8'hC3, b, 8'h5A, ~b};
  endfunction

  // Monitor: samples one time unit before each rising edge.
  logic [31:0] out_data_q[$];
  logic [31:0] out_idx_q[$];
  int          out_cyc_q[$];
  int          gcyc     = 0;
  int          done_cnt = 0;
  int          dma_iss  = 0;
  initial begin
    forever begin
      @(negedge clk);
      #4;
      gcyc++;
      if (rst) begin
        if (dbus.dma_out_valid && dbus.dma_out_ready) begin
          out_data_q.push_back(dbus.dma_out_data);
          out_idx_q.push_back(32'(dbus.dma_out_index));
          out_cyc_q.push_back(gcyc);
        end
        if (dbus.dma_done) done_cnt++;
        if (dbus.mem_re && (dbus.cpu_stall || !(dbus.cpu_re || dbus.cpu_we))) dma_iss++;
      end
    end
  end

  int stall_pos[$];

  // Pulses start for one cycle; returns at the following falling edge.
  task automatic start_dma(input logic [31:0] src, input logic [7:0] len);
    @(negedge clk);
    dbus.dma_start = 1'b1;
    dbus.dma_src   = src;
    dbus.dma_len   = len;
    @(negedge clk);
    dbus.dma_start = 1'b0;
  endtask

  // Cycle n0 is the current one; returns the cycle number where done is seen.
  task automatic wait_done(input int n0, input int maxc, output int n);
    n = n0;
    forever begin
      #1;
      if (dbus.cpu_stall) stall_pos.push_back(n);
      if (dbus.dma_done || n >= maxc) break;
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", 32'(dbus.dma_done), 32'd1);
  endtask

  task automatic check_words(input string tag, input int base, input int cnt);
    check_eq({tag, "_count"}, 32'(out_data_q.size()), 32'(cnt));
    for (int i = 0; i < cnt && i < out_data_q.size(); i++) begin
      check_eq({tag, "_data"}, out_data_q[i], pat(base + i));
      check_eq({tag, "_idx"}, out_idx_q[i], 32'(i));
    end
  endtask

  task automatic clear_q();
    out_data_q.delete();
    out_idx_q.delete();
    out_cyc_q.delete();
    stall_pos.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    int i0;
    logic stable_ok;

    for (int a = 0; a < 256; a++) mem[a] = pat(a);
    // Test-plan words A..D at 0x20..0x23 follow pat() as well.
    rst            = 1'b0;
    dbus.cpu_re    = 1'b0;
    dbus.cpu_we    = 1'b0;
    dbus.cpu_addr  = '0;
    dbus.cpu_wdata = '0;
    dbus.dma_start = 1'b0;
    dbus.dma_src   = '0;
    dbus.dma_len   = '0;
    dbus.dma_out_ready = 1'b1;
    dbus.mem_rdata = '0;

    // ---------------- Reset state ----------------
    @(negedge clk);
    #1;
    check_eq("rst_busy",  32'(dbus.dma_busy), 32'd0);
    check_eq("rst_done",  32'(dbus.dma_done), 32'd0);
    check_eq("rst_valid", 32'(dbus.dma_out_valid), 32'd0);
    check_eq("rst_stall", 32'(dbus.cpu_stall), 32'd0);
    check_eq("rst_odata", dbus.dma_out_data, 32'd0);
    check_eq("rst_oidx",  32'(dbus.dma_out_index), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- CPU only ----------------
    @(negedge clk);
    dbus.cpu_we = 1'b1; dbus.cpu_addr = 32'h10; dbus.cpu_wdata = 32'h0000_DEAD;
    #1;
    check_eq("cpu_wr_stall", 32'(dbus.cpu_stall), 32'd0);
    check_eq("cpu_wr_memwe", 32'(dbus.mem_we), 32'd1);
    @(negedge clk);
    dbus.cpu_we = 1'b0; dbus.cpu_re = 1'b1;
    #1;
    check_eq("cpu_rd_stall", 32'(dbus.cpu_stall), 32'd0);
    check_eq("cpu_rd_memre", 32'(dbus.mem_re), 32'd1);
    @(negedge clk);
    dbus.cpu_re = 1'b0;
    #1;
    check_eq("cpu_rdata", dbus.cpu_rdata, 32'h0000_DEAD);

    // ---------------- DMA alone, len 4 ----------------
    clear_q();
    d0 = done_cnt;
    start_dma(32'h20, 8'd4);
    #1;
    check_eq("dma1_first_re",   32'(dbus.mem_re), 32'd1);
    check_eq("dma1_first_addr", dbus.mem_addr, 32'h20);
    check_eq("dma1_busy",       32'(dbus.dma_busy), 32'd1);
    wait_done(1, 40, n);
    check_eq("dma1_done_cyc", 32'(n), 32'd11);
    @(negedge clk);
    #1;
    check_eq("dma1_busy_drop", 32'(dbus.dma_busy), 32'd0);
    check_eq("dma1_done_once", 32'(done_cnt - d0), 32'd1);
    check_words("dma1", 32'h20, 4);
    for (int i = 1; i < out_cyc_q.size(); i++)
      check_eq("dma1_spacing", 32'(out_cyc_q[i] - out_cyc_q[i-1]), 32'd2);

    // ---------------- Starvation under continuous CPU reads ----------------
    clear_q();
    dbus.cpu_re = 1'b1; dbus.cpu_addr = 32'h80;
    start_dma(32'h40, 8'd2);
    wait_done(1, 40, n);
    dbus.cpu_re = 1'b0;
    check_eq("starve_done_cyc", 32'(n), 32'd15);
    check_eq("starve_nstall",   32'(stall_pos.size()), 32'd2);
    if (stall_pos.size() == 2) begin
      check_eq("starve_stall0", 32'(stall_pos[0]), 32'd5);
      check_eq("starve_stall1", 32'(stall_pos[1]), 32'd11);
    end
    check_words("starve", 32'h40, 2);

    // ---------------- Back-pressure ----------------
    clear_q();
    start_dma(32'h60, 8'd3);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    dbus.dma_out_ready = 1'b0;
    @(negedge clk);
    i0 = dma_iss;
    stable_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!dbus.dma_out_valid || dbus.dma_out_data !== pat(32'h61) ||
          dbus.dma_out_index !== 8'd1 || dbus.mem_re) stable_ok = 1'b0;
      @(negedge clk);
    end
    check_eq("bp_hold_stable", 32'(stable_ok), 32'd1);
    check_eq("bp_no_issue",    32'(dma_iss - i0), 32'd0);
    dbus.dma_out_ready = 1'b1;
    wait_done(15, 60, n);
    check_eq("bp_done_cyc", 32'(n), 32'd19);
    check_words("bp", 32'h60, 3);

    // ---------------- Zero length ----------------
    i0 = dma_iss;
    start_dma(32'h70, 8'd0);
    #1;
    check_eq("len0_done",  32'(dbus.dma_done), 32'd1);
    check_eq("len0_busy",  32'(dbus.dma_busy), 32'd1);
    @(negedge clk);
    #1;
    check_eq("len0_done_clr", 32'(dbus.dma_done), 32'd0);
    check_eq("len0_no_re",    32'(dma_iss - i0), 32'd0);

    // ---------------- Start while busy is ignored ----------------
    clear_q();
    start_dma(32'h30, 8'd2);
    dbus.dma_start = 1'b1; dbus.dma_src = 32'h90; dbus.dma_len = 8'd5;
    #1;
    @(negedge clk);
    dbus.dma_start = 1'b0;
    wait_done(2, 40, n);
    check_eq("ign_done_cyc", 32'(n), 32'd7);
    check_words("ign", 32'h30, 2);
    @(negedge clk);

    // ---------------- Reset mid-transfer ----------------
    clear_q();
    start_dma(32'hA0, 8'd5);
    for (int k = 0; k < 20 && out_data_q.size() < 2; k++) @(negedge clk);
    check_eq("mid_words_before_rst", 32'(out_data_q.size()), 32'd2);
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_busy",  32'(dbus.dma_busy), 32'd0);
    check_eq("mid_rst_valid", 32'(dbus.dma_out_valid), 32'd0);
    check_eq("mid_rst_odata", dbus.dma_out_data, 32'd0);
    check_eq("mid_rst_oidx",  32'(dbus.dma_out_index), 32'd0);
    check_eq("mid_rst_memre", 32'(dbus.mem_re), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_no_done", 32'(done_cnt - d0), 32'd0);
    clear_q();
    start_dma(32'hB0, 8'd2);
    wait_done(1, 40, n);
    check_eq("post_rst_done_cyc", 32'(n), 32'd7);
    check_words("post_rst", 32'hB0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
